// File: rtl/nukv_rdcmd_arbiter.sv
// nukv_rdcmd_arbiter: shares one memory read-command channel between two
// requesters and routes the in-order read responses back to their issuers.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req{0,1}_cmd_data/valid/last/ready  requester command streams (groups end on last)
//   mem_cmd_data/valid/ready         command channel to memory
//   mem_rsp_data/valid/ready         in-order response channel from memory
//   rsp{0,1}_data/valid/ready        responses demultiplexed per requester
//   outstanding                      commands issued and not yet answered
//   err_unexpected_rsp               sticky: response seen with nothing outstanding

// Generic synchronous FIFO, power-of-two depth, first-word-fall-through read.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: a push is taken only with a free slot or a same-cycle pop.
module nukv_fifo #(
    parameter int WIDTH     = 1,
    parameter int DEPTH_LOG = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_vld,
    input  logic [WIDTH-1:0]     push_dat,
    output logic                 pop_vld,
    output logic [WIDTH-1:0]     pop_dat,
    input  logic                 pop_rdy,
    output logic [DEPTH_LOG:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   cnt;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop_rdy & (cnt != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_push = push_vld & ((cnt != FULL_CNT) | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign pop_vld = (cnt != '0);
    assign pop_dat = mem[rd_ptr];
    assign count   = cnt;
endmodule

// Group-granular round-robin arbiter for memory read commands with tag-based response demux.
// Latency: grant decided one cycle after request (one idle bubble per group); responses pass combinationally.
// Backpressure: commands stall on mem_cmd_ready or a full tag FIFO; responses stall on the owner's rspN_ready.
module nukv_rdcmd_arbiter #(
    parameter int CMD_WIDTH     = 32,
    parameter int DATA_WIDTH    = 512,
    parameter int TAG_DEPTH_LOG = 5
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [CMD_WIDTH-1:0]     req0_cmd_data,
    input  logic                     req0_cmd_valid,
    input  logic                     req0_cmd_last,
    output logic                     req0_cmd_ready,

    input  logic [CMD_WIDTH-1:0]     req1_cmd_data,
    input  logic                     req1_cmd_valid,
    input  logic                     req1_cmd_last,
    output logic                     req1_cmd_ready,

    output logic [CMD_WIDTH-1:0]     mem_cmd_data,
    output logic                     mem_cmd_valid,
    input  logic                     mem_cmd_ready,

    input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
    input  logic                     mem_rsp_valid,
    output logic                     mem_rsp_ready,

    output logic [DATA_WIDTH-1:0]    rsp0_data,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,

    output logic [DATA_WIDTH-1:0]    rsp1_data,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,

    output logic [TAG_DEPTH_LOG:0]   outstanding,
    output logic                     err_unexpected_rsp
);
    localparam logic [TAG_DEPTH_LOG:0] FULL_CNT = (TAG_DEPTH_LOG + 1)'(1 << TAG_DEPTH_LOG);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;

    logic   cmd_fire;
    logic   cmd_last;
    logic   rsp_fire;
    logic   full;
    logic   has_tag;
    logic   head_tag;

    // Tag FIFO: one bit per outstanding command naming its requester.
    nukv_fifo #(
        .WIDTH     (1),
        .DEPTH_LOG (TAG_DEPTH_LOG)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_fire),
        .push_dat (state == ST_GRANT1),
        .pop_vld  (has_tag),
        .pop_dat  (head_tag),
        .pop_rdy  (rsp_fire),
        .count    (outstanding)
    );

    // Response demux: the FIFO head names the owner of the response now on the bus.
    assign mem_rsp_ready = has_tag & (head_tag ? rsp1_ready : rsp0_ready);
    assign rsp0_valid    = mem_rsp_valid & has_tag & ~head_tag;
    assign rsp1_valid    = mem_rsp_valid & has_tag &  head_tag;
    assign rsp0_data     = mem_rsp_data;
    assign rsp1_data     = mem_rsp_data;
    assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

    // A response retiring this cycle frees a slot, so a full FIFO can still
    // accept a command in the same cycle.
    assign full = (outstanding == FULL_CNT) & ~rsp_fire;

    // State register; prio flips to the other requester at each group end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_fire & cmd_last) prio <= (state == ST_GRANT0);
        end
    end

    // Next-state logic; the idle decision forwards nothing in that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req0_cmd_valid & req1_cmd_valid)
                    state_nxt = prio ? ST_GRANT1 : ST_GRANT0;
                else if (req0_cmd_valid)
                    state_nxt = ST_GRANT0;
                else if (req1_cmd_valid)
                    state_nxt = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                if (cmd_fire & cmd_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: granted requester is passed straight through to memory.
    always_comb begin
        mem_cmd_data   = '0;
        mem_cmd_valid  = 1'b0;
        req0_cmd_ready = 1'b0;
        req1_cmd_ready = 1'b0;
        cmd_last       = 1'b0;
        case (state)
            ST_GRANT0: begin
                mem_cmd_data   = req0_cmd_data;
                mem_cmd_valid  = req0_cmd_valid & ~full;
                req0_cmd_ready = mem_cmd_ready & ~full;
                cmd_last       = req0_cmd_last;
            end
            ST_GRANT1: begin
                mem_cmd_data   = req1_cmd_data;
                mem_cmd_valid  = req1_cmd_valid & ~full;
                req1_cmd_ready = mem_cmd_ready & ~full;
                cmd_last       = req1_cmd_last;
            end
            default: ;
        endcase
    end

    assign cmd_fire = mem_cmd_valid & mem_cmd_ready;

    // Sticky error; the stray response itself is never acknowledged.
    always_ff @(posedge clk) begin
        if (rst)
            err_unexpected_rsp <= 1'b0;
        else if (mem_rsp_valid & ~has_tag)
            err_unexpected_rsp <= 1'b1;
    end
endmodule
